// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and ticks on the final count.
module fifo_uart_tx_baud #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    logic [CNT_WIDTH-1:0] cnt;

    assign tick = run && (cnt == CNT_WIDTH'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one word per frame and serialises it LSB first.
// Define FIFO_UART_TX_STOP2_EN to add the stop2 input (optional second stop bit).
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  par_en,
    input  logic                  par_typ,
`ifdef FIFO_UART_TX_STOP2_EN
    input  logic                  stop2,
`endif
    output logic                  fifo_rd_inc,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_bit_q, par_bit_nxt;
    logic                  tx_nxt;
    logic                  tick;
    logic                  stop_last;
    logic                  pop;
`ifdef FIFO_UART_TX_STOP2_EN
    logic                  stop2_q, stop2_nxt;
    logic                  stop_sec, stop_sec_nxt;
`endif

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
        logic p;
        p = ^d;
        case (typ)
            PAR_EVEN: p = ^d;
            PAR_ODD:  p = ~(^d);
            default:  p = ^d;
        endcase
        return p;
    endfunction

    fifo_uart_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(pop),
        .run  (busy),
        .tick (tick)
    );

    assign busy = (state != IDLE);

`ifdef FIFO_UART_TX_STOP2_EN
    assign stop_last = !stop2_q || stop_sec;
`else
    assign stop_last = 1'b1;
`endif

    // A pop is only possible while idle or in the very last stop cycle, so one pop per frame.
    assign pop = tx_en && !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && tick && stop_last));
    assign fifo_rd_inc = pop && !rst;

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        par_en_nxt  = par_en_q;
        par_bit_nxt = par_bit_q;
`ifdef FIFO_UART_TX_STOP2_EN
        stop2_nxt    = stop2_q;
        stop_sec_nxt = stop_sec;
`endif
        if (pop) begin
            state_nxt   = START;
            shreg_nxt   = fifo_rd_data;
            bit_idx_nxt = '0;
            par_en_nxt  = par_en;
            par_bit_nxt = parity_bit(fifo_rd_data, par_typ);
`ifdef FIFO_UART_TX_STOP2_EN
            stop2_nxt    = stop2;
            stop_sec_nxt = 1'b0;
`endif
        end else if (tick) begin
            case (state)
                START: state_nxt = DATA;
                DATA: begin
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        bit_idx_nxt = '0;
                        state_nxt   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        shreg_nxt   = shreg >> 1;
                    end
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    if (stop_last) begin
                        state_nxt = IDLE;
                    end
`ifdef FIFO_UART_TX_STOP2_EN
                    else begin
                        stop_sec_nxt = 1'b1;
                    end
`endif
                end
                default: state_nxt = state;
            endcase
        end

        // Line level is registered, so it is derived from the upcoming state.
        tx_nxt = TX_IDLE_LEVEL;
        case (state_nxt)
            START:   tx_nxt = START_LEVEL;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_bit_nxt;
            default: tx_nxt = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            par_en_q <= 1'b0;
            tx_out   <= TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_STOP2_EN
            stop2_q  <= 1'b0;
            stop_sec <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            bit_idx  <= bit_idx_nxt;
            par_en_q <= par_en_nxt;
            tx_out   <= tx_nxt;
`ifdef FIFO_UART_TX_STOP2_EN
            stop2_q  <= stop2_nxt;
            stop_sec <= stop_sec_nxt;
`endif
        end
    end

    // Payload registers carry no reset; they are always reloaded on a pop before use.
    always_ff @(posedge clk) begin
        shreg     <= shreg_nxt;
        par_bit_q <= par_bit_nxt;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx against a frame-level queue model of the serial line.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          fifo_rd_inc, tx_out, busy;
`ifdef FIFO_UART_TX_STOP2_EN
    logic          stop2 = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] fifo_q[$];
    logic          line_q[$];
    logic          e_pop, e_tx, e_busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .par_en      (par_en),
        .par_typ     (par_typ),
`ifdef FIFO_UART_TX_STOP2_EN
        .stop2       (stop2),
`endif
        .fifo_rd_inc (fifo_rd_inc),
        .tx_out      (tx_out),
        .busy        (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? DW'($urandom) : fifo_q[0];
    endtask

    // The line is free for a new frame when nothing or only the final stop cycle remains queued.
    task automatic model_expect();
        e_busy = (line_q.size() != 0);
        e_tx   = e_busy ? line_q[0] : 1'b1;
        e_pop  = !rst && tx_en && (fifo_q.size() != 0) && (line_q.size() <= 1);
    endtask

    task automatic push_level(input logic lvl, input int n);
        for (int k = 0; k < n; k++) line_q.push_back(lvl);
    endtask

    task automatic advance();
        logic [DW-1:0] w;
        int nstop;
        model_expect();
        @(posedge clk);
        cyc++;
        if (line_q.size() != 0) void'(line_q.pop_front());
        if (e_pop) begin
            w = fifo_q.pop_front();
            push_level(1'b0, CPB);
            for (int b = 0; b < DW; b++) push_level(w[b], CPB);
            if (par_en) push_level((($countones(w) % 2) == 1) != par_typ, CPB);
            nstop = CPB;
`ifdef FIFO_UART_TX_STOP2_EN
            if (stop2) nstop = 2 * CPB;
`endif
            push_level(1'b1, nstop);
        end
        #1;
        drive_fifo();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_en = 1'b1;
        fifo_q.push_back(8'h99);
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fifo_rd_inc, tx_out, busy} !== 3'b010)
            $display("FAIL reset_hold inc/tx/busy got %b%b%b want 010", fifo_rd_inc, tx_out, busy);
        if ({fifo_rd_inc, tx_out, busy} !== 3'b010) failures++;
        fifo_q.delete();
        line_q.delete();
        drive_fifo();
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_inc, tx_out, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_release inc/tx/busy got %b%b%b want 010", fifo_rd_inc, tx_out, busy);
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0, pop_cnt = 0, p = -1, off;
        logic [9:0] seen = '0;
        logic [9:0] want = 10'b1101001010;
        par_en = 1'b0;
        tx_en = 1'b1;
        fifo_q.push_back(8'hA5);
        drive_fifo();
        #1;
        for (int i = 0; i < 200; i++) begin
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL single cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            if (fifo_rd_inc) begin pop_cnt++; p = i; end
            if (busy) busy_cnt++;
            off = i - p - 1;
            if (p >= 0 && off >= 0 && (off % CPB) == CPB / 2 && (off / CPB) < 10) seen[off / CPB] = tx_out;
            advance();
        end
        checks++;
        if (pop_cnt != 1) begin failures++; $display("FAIL single_pops got %0d want 1", pop_cnt); end
        checks++;
        if (busy_cnt != 160) begin failures++; $display("FAIL single_busy got %0d want 160", busy_cnt); end
        checks++;
        if (seen !== want) begin failures++; $display("FAIL single_bits got %b want %b", seen, want); end
    endtask

    task automatic test_parity();
        int busy_cnt, p, off;
        logic pbit;
        for (int t = 0; t < 2; t++) begin
            busy_cnt = 0;
            p = -1;
            pbit = 1'bx;
            par_en = 1'b1;
            par_typ = (t == 1);
            fifo_q.push_back(8'h07);
            drive_fifo();
            #1;
            for (int i = 0; i < 220; i++) begin
                model_expect();
                checks++;
                if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                    failures++;
                    $display("FAIL parity cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                             cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
                end
                if (fifo_rd_inc) p = i;
                if (busy) busy_cnt++;
                off = i - p - 1;
                if (p >= 0 && off == 9 * CPB + CPB / 2) pbit = tx_out;
                // Mid-frame parity control changes must not reach the frame in flight.
                if (i == 30) par_typ = ~par_typ;
                advance();
            end
            checks++;
            if (busy_cnt != 176) begin failures++; $display("FAIL parity_len typ=%0d got %0d want 176", t, busy_cnt); end
            checks++;
            if (pbit !== (t == 0)) begin failures++; $display("FAIL parity_bit typ=%0d got %b want %b", t, pbit, (t == 0)); end
        end
        par_en = 1'b0;
        par_typ = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pops[$];
        int busy_cnt = 0;
        tx_en = 1'b1;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        drive_fifo();
        #1;
        for (int i = 0; i < 520; i++) begin
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL b2b cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            if (fifo_rd_inc) pops.push_back(i);
            if (busy) busy_cnt++;
            advance();
        end
        checks++;
        if (pops.size() != 3) begin
            failures++;
            $display("FAIL b2b_pops got %0d want 3", pops.size());
        end else begin
            checks++;
            if (pops[1] - pops[0] != 160 || pops[2] - pops[1] != 160) begin
                failures++;
                $display("FAIL b2b_spacing got %0d,%0d want 160,160", pops[1] - pops[0], pops[2] - pops[1]);
            end
        end
        checks++;
        if (busy_cnt != 480) begin failures++; $display("FAIL b2b_busy got %0d want 480", busy_cnt); end
    endtask

    task automatic test_tx_en();
        int pop_cnt = 0, low_cnt = 0;
        tx_en = 1'b0;
        fifo_q.push_back(8'h55);
        drive_fifo();
        #1;
        for (int i = 0; i < 261; i++) begin
            if (i == 40) begin fifo_q.push_back(8'h66); tx_en = 1'b1; drive_fifo(); #1; end
            if (i == 61) begin tx_en = 1'b0; #1; end
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL tx_en cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            if (fifo_rd_inc) pop_cnt++;
            if (i < 40 && !tx_out) low_cnt++;
            if (i == 39) begin
                checks++;
                if (pop_cnt != 0 || low_cnt != 0) begin
                    failures++;
                    $display("FAIL tx_en_off pops/low got %0d/%0d want 0/0", pop_cnt, low_cnt);
                end
            end
            advance();
        end
        checks++;
        if (pop_cnt != 1) begin failures++; $display("FAIL tx_en_midframe pops got %0d want 1", pop_cnt); end
        fifo_q.delete();
        drive_fifo();
        #1;
    endtask

    task automatic test_reset_mid();
        tx_en = 1'b1;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h5A);
        drive_fifo();
        #1;
        for (int i = 0; i < 51; i++) begin
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL rstmid_pre cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            advance();
        end
        rst = 1'b1;
        line_q.delete();
        #1;
        checks++;
        if ({fifo_rd_inc, tx_out, busy} !== 3'b010) begin
            failures++;
            $display("FAIL rstmid_abort inc/tx/busy got %b%b%b want 010", fifo_rd_inc, tx_out, busy);
        end
        for (int i = 0; i < 3; i++) advance();
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_rd_inc !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_repop inc got %b want 1", fifo_rd_inc);
        end
        for (int i = 0; i < 200; i++) begin
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL rstmid_post cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            advance();
        end
    endtask

`ifdef FIFO_UART_TX_STOP2_EN
    task automatic test_stop2();
        int pops[$];
        int high_cnt = 0;
        tx_en = 1'b1;
        par_en = 1'b0;
        stop2 = 1'b1;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h00);
        drive_fifo();
        #1;
        for (int i = 0; i < 400; i++) begin
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL stop2 cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            if (fifo_rd_inc) pops.push_back(i);
            if (pops.size() == 1 && i > pops[0] && tx_out) high_cnt++;
            advance();
        end
        checks++;
        if (pops.size() != 2) begin
            failures++;
            $display("FAIL stop2_pops got %0d want 2", pops.size());
        end else begin
            checks++;
            if (pops[1] - pops[0] != 176) begin
                failures++;
                $display("FAIL stop2_spacing got %0d want 176", pops[1] - pops[0]);
            end
            checks++;
            if (high_cnt != 32) begin failures++; $display("FAIL stop2_len got %0d want 32", high_cnt); end
        end
        stop2 = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) fifo_q.push_back(DW'($urandom));
            tx_en   = ($urandom_range(0, 9) != 0);
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
`ifdef FIFO_UART_TX_STOP2_EN
            stop2   = 1'($urandom);
`endif
            drive_fifo();
            #1;
            model_expect();
            checks++;
            if ({fifo_rd_inc, tx_out, busy} !== {e_pop, e_tx, e_busy}) begin
                failures++;
                $display("FAIL random cyc=%0d inc/tx/busy got %b%b%b want %b%b%b",
                         cyc, fifo_rd_inc, tx_out, busy, e_pop, e_tx, e_busy);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_tx_en();
        test_reset_mid();
`ifdef FIFO_UART_TX_STOP2_EN
        test_stop2();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
